// File: rtl/sram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module  : sram_arbiter                                                      |
// | Brief   : Two-master arbiter onto one 1-cycle-latency SRAM-style slave.     |
// |           Optional macro SRAM_ARBITER_RR_EN selects round-robin contention  |
// |           (default: fixed priority, m0 wins).                               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sram_arbiter #(
   parameter int LEN_ADDR = 64,
   parameter int LEN_DATA = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  m0_ena,
   input  logic [LEN_ADDR-1:0]   m0_addra,
   input  logic [LEN_DATA-1:0]   m0_dina,
   input  logic [LEN_DATA/8-1:0] m0_wea,
   output logic                  m0_gnt,
   output logic [LEN_DATA-1:0]   m0_douta,
   output logic                  m0_rvalid,

   input  logic                  m1_ena,
   input  logic [LEN_ADDR-1:0]   m1_addra,
   input  logic [LEN_DATA-1:0]   m1_dina,
   input  logic [LEN_DATA/8-1:0] m1_wea,
   output logic                  m1_gnt,
   output logic [LEN_DATA-1:0]   m1_douta,
   output logic                  m1_rvalid,

   output logic [LEN_ADDR-1:0]   s_addra,
   output logic [LEN_DATA-1:0]   s_dina,
   input  logic [LEN_DATA-1:0]   s_douta,
   output logic                  s_ena,
   output logic [LEN_DATA/8-1:0] s_wea
);

`ifdef SRAM_ARBITER_RR_EN
   localparam bit c_rr_en = 1'b1;
`else
   localparam bit c_rr_en = 1'b0;
`endif

   logic last_q, last_d;
   logic rsel_q, rsel_d;
   logic rvalid_q, rvalid_d;

   logic w_gnt0;
   logic w_gnt1;
   logic w_contend_pick1;

   // On contention, round-robin favours the master that was not granted last.
   assign w_contend_pick1 = c_rr_en ? ~last_q : 1'b0;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         if (m0_ena && m1_ena) begin
            w_gnt1 = w_contend_pick1;
            w_gnt0 = ~w_contend_pick1;
         end else begin
            w_gnt0 = m0_ena;
            w_gnt1 = m1_ena;
         end
      end
   end

   assign m0_gnt = w_gnt0;
   assign m1_gnt = w_gnt1;

   always_comb begin
      s_ena   = w_gnt0 | w_gnt1;
      s_addra = '0;
      s_dina  = '0;
      s_wea   = '0;
      if (w_gnt0) begin
         s_addra = m0_addra;
         s_dina  = m0_dina;
         s_wea   = m0_wea;
      end else if (w_gnt1) begin
         s_addra = m1_addra;
         s_dina  = m1_dina;
         s_wea   = m1_wea;
      end
   end

   always_comb begin
      last_d   = last_q;
      rsel_d   = rsel_q;
      rvalid_d = 1'b0;
      if (w_gnt0 || w_gnt1) begin
         last_d   = w_gnt1;
         rsel_d   = w_gnt1;
         rvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q   <= 1'b1;
         rsel_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         last_q   <= last_d;
         rsel_q   <= rsel_d;
         rvalid_q <= rvalid_d;
      end
   end

   // A response still in flight when reset rises is dropped.
   assign m0_rvalid = rvalid_q & ~rsel_q & ~rst;
   assign m1_rvalid = rvalid_q &  rsel_q & ~rst;
   assign m0_douta  = s_douta;
   assign m1_douta  = s_douta;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module  : tb_sram_arbiter                                                   |
// | Brief   : Directed scoreboard bench for sram_arbiter with an SRAM model.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_sram_arbiter;

   localparam int LA = 64;
   localparam int LD = 64;
   localparam int LW = LD / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_ena, m1_ena;
   logic [LA-1:0] m0_addra, m1_addra;
   logic [LD-1:0] m0_dina, m1_dina;
   logic [LW-1:0] m0_wea, m1_wea;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [LD-1:0] m0_douta, m1_douta;
   logic [LA-1:0] s_addra;
   logic [LD-1:0] s_dina;
   logic [LD-1:0] s_douta;
   logic          s_ena;
   logic [LW-1:0] s_wea;

   always #5 clk = ~clk;

   sram_arbiter #(.LEN_ADDR(LA), .LEN_DATA(LD)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_ena    (m0_ena),
      .m0_addra  (m0_addra),
      .m0_dina   (m0_dina),
      .m0_wea    (m0_wea),
      .m0_gnt    (m0_gnt),
      .m0_douta  (m0_douta),
      .m0_rvalid (m0_rvalid),
      .m1_ena    (m1_ena),
      .m1_addra  (m1_addra),
      .m1_dina   (m1_dina),
      .m1_wea    (m1_wea),
      .m1_gnt    (m1_gnt),
      .m1_douta  (m1_douta),
      .m1_rvalid (m1_rvalid),
      .s_addra   (s_addra),
      .s_dina    (s_dina),
      .s_douta   (s_douta),
      .s_ena     (s_ena),
      .s_wea     (s_wea)
   );

   function automatic logic [LD-1:0] init_val(input logic [LA-1:0] a);
      return {32'hDEADBEEF, a[31:0]};
   endfunction

   function automatic logic [LD-1:0] merge(input logic [LD-1:0] old_v,
                                           input logic [LD-1:0] new_v,
                                           input logic [LW-1:0] we);
      logic [LD-1:0] r;
      r = old_v;
      for (int b = 0; b < LW; b++)
         if (we[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   // Slave SRAM model: 1-cycle read latency, byte write enables.
   logic [LD-1:0] sram_mem [logic [LA-1:0]];
   logic [LD-1:0] sram_cur;
   initial s_douta = '0;
   always @(posedge clk) begin
      if (s_ena) begin
         sram_cur = sram_mem.exists(s_addra) ? sram_mem[s_addra] : init_val(s_addra);
         if (s_wea == '0) s_douta <= sram_cur;
         else             sram_mem[s_addra] = merge(sram_cur, s_dina, s_wea);
      end
   end

   // Scoreboard reference state.
   typedef struct {
      bit            m;
      bit            rd;
      logic [LD-1:0] data;
   } resp_t;

   resp_t         sb_q[$];
   logic [LD-1:0] ref_mem [logic [LA-1:0]];
   bit            m_last = 1'b1;
   int            errors = 0;
   int            checks = 0;

   task automatic chk(input string tag, input logic [LD-1:0] obs, input logic [LD-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic cycle(input bit r,
                        input bit e0, input logic [LA-1:0] a0, input logic [LD-1:0] d0, input logic [LW-1:0] w0,
                        input bit e1, input logic [LA-1:0] a1, input logic [LD-1:0] d1, input logic [LW-1:0] w1);
      resp_t         p;
      bit            has, g0, g1;
      logic [LA-1:0] ea;
      logic [LD-1:0] cur;
      @(negedge clk);
      rst = r;
      m0_ena = e0; m0_addra = a0; m0_dina = d0; m0_wea = w0;
      m1_ena = e1; m1_addra = a1; m1_dina = d1; m1_wea = w1;
      #1;
      p = '{m: 1'b0, rd: 1'b0, data: '0};
      has = (sb_q.size() > 0);
      if (has) p = sb_q.pop_front();
      chk("m0_rvalid", {63'd0, m0_rvalid}, {63'd0, has && !r && !p.m});
      chk("m1_rvalid", {63'd0, m1_rvalid}, {63'd0, has && !r &&  p.m});
      if (has && !r && p.rd) begin
         if (p.m) chk("m1_douta", m1_douta, p.data);
         else     chk("m0_douta", m0_douta, p.data);
      end
      g0 = 1'b0;
      g1 = 1'b0;
      if (!r) begin
         if (e0 && e1) begin
`ifdef SRAM_ARBITER_RR_EN
            g0 = m_last;
            g1 = !m_last;
`else
            g0 = 1'b1;
`endif
         end else begin
            g0 = e0;
            g1 = e1;
         end
      end
      chk("m0_gnt", {63'd0, m0_gnt}, {63'd0, g0});
      chk("m1_gnt", {63'd0, m1_gnt}, {63'd0, g1});
      chk("s_ena",  {63'd0, s_ena},  {63'd0, g0 | g1});
      chk("s_addra", s_addra, g0 ? a0 : (g1 ? a1 : '0));
      chk("s_dina",  s_dina,  g0 ? d0 : (g1 ? d1 : '0));
      chk("s_wea",   {56'd0, s_wea}, {56'd0, g0 ? w0 : (g1 ? w1 : 8'h00)});
      if (g0 || g1) begin
         ea  = g1 ? a1 : a0;
         cur = ref_mem.exists(ea) ? ref_mem[ea] : init_val(ea);
         p.m = g1;
         p.rd = ((g1 ? w1 : w0) == '0);
         p.data = cur;
         if (!p.rd) ref_mem[ea] = merge(cur, g1 ? d1 : d0, g1 ? w1 : w0);
         sb_q.push_back(p);
      end
      if (r) m_last = 1'b1;
      else if (g0 || g1) m_last = g1;
   endtask

   task automatic idle(input bit r);
      cycle(r, 0, '0, '0, '0, 0, '0, '0, '0);
   endtask

   initial begin
      rst = 1'b1;
      m0_ena = 0; m0_addra = '0; m0_dina = '0; m0_wea = '0;
      m1_ena = 0; m1_addra = '0; m1_dina = '0; m1_wea = '0;

      // Reset with both masters requesting: no grants, no responses.
      cycle(1, 1, 64'h8, '0, '0, 1, 64'h18, '0, '0);
      idle(1);
      idle(0);

      // Single master read.
      cycle(0, 1, 64'h10, '0, '0, 0, '0, '0, '0);
      idle(0);

      // Contention, 4 cycles; m1 holds its request until granted.
      for (int i = 0; i < 4; i++)
         cycle(0, 1, 64'h20 + 64'(i), '0, '0, 1, 64'h30, '0, '0);
      cycle(0, 0, '0, '0, '0, 1, 64'h30, '0, '0);
      idle(0);

      // m1 partial write, then read it back.
      cycle(0, 0, '0, '0, '0, 1, 64'h40, 64'h1122334455667788, 8'h0F);
      cycle(0, 0, '0, '0, '0, 1, 64'h40, '0, '0);
      idle(0);

      // Back-to-back ownership switch: m0 full write then m1 read same address.
      cycle(0, 1, 64'h50, 64'hA5A5_5A5A_0123_4567, 8'hFF, 0, '0, '0, '0);
      cycle(0, 0, '0, '0, '0, 1, 64'h50, '0, '0);
      cycle(0, 1, 64'h50, '0, 8'h00, 0, '0, '0, '0);

      // Reset mid-access drops the in-flight response; contention after release.
      cycle(0, 1, 64'h60, '0, '0, 0, '0, '0, '0);
      cycle(1, 1, 64'h60, 64'hFFFF, 8'hFF, 0, '0, '0, '0);
      cycle(0, 1, 64'h70, '0, '0, 1, 64'h78, '0, '0);
      cycle(0, 0, '0, '0, '0, 1, 64'h78, '0, '0);

      // Idle: pointer holds, next contention resolves from it.
      idle(0);
      idle(0);
      idle(0);
      cycle(0, 1, 64'h80, '0, '0, 1, 64'h88, '0, '0);
      cycle(0, 1, 64'h80, '0, '0, 1, 64'h88, '0, '0);
      cycle(0, 0, '0, '0, '0, 1, 64'h88, '0, '0);
      idle(0);
      idle(0);

      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
